// File: rtl/sqrt_pkg.sv
// Shared types and elaboration helpers for the sequential square-root unit.
package sqrt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    function automatic bit width_legal(input int w);
        return (w >= 4) && ((w % 2) == 0);
    endfunction

    // Counter must hold OUT_W-1; never let it collapse to zero bits.
    function automatic int cnt_width(input int out_w);
        return (out_w > 1) ? $clog2(out_w) : 1;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring bit-pair iteration of the integer square root (combinational).
module sqrt_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] x_nxt,
    output logic [WIDTH-1:0] y_nxt
);

    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y_sh;

    // y and m never overlap, so OR is the same as adding the trial bit.
    assign b    = y | m;
    assign y_sh = y >> 1;

    always_comb begin
        x_nxt = x;
        y_nxt = y_sh;
        if (x >= b) begin
            x_nxt = x - b;
            y_nxt = y_sh | m;
        end
    end

endmodule

// File: rtl/sqrt_seq_param.sv
// Sequential floor(sqrt(x)) with remainder, one root bit per clock, start/busy handshake.
module sqrt_seq_param
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     x_bi,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [WIDTH/2-1:0]   y_bo,
    output logic [WIDTH/2:0]     rem_bo
);

    localparam int OUT_W = WIDTH / 2;
    localparam int CNT_W = cnt_width(OUT_W);
    localparam logic [WIDTH-1:0] M_INIT = WIDTH'(1) << (WIDTH - 2);

    generate
        if (!width_legal(WIDTH)) begin : g_bad_width
            $error("sqrt_seq_param: WIDTH must be even and >= 4");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_d;
    logic [OUT_W-1:0] y_res_d;
    logic [OUT_W:0]   rem_res_d;
    logic [WIDTH-1:0] x_step, y_step;

    sqrt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .x     (x_q),
        .y     (y_q),
        .m     (m_q),
        .x_nxt (x_step),
        .y_nxt (y_step)
    );

    assign busy_o = (state_q == WORK);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        y_res_d   = y_bo;
        rem_res_d = rem_bo;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = WORK;
                    x_d     = x_bi;
                    y_d     = '0;
                    m_d     = M_INIT;
                    cnt_d   = CNT_W'(OUT_W - 1);
                end
            end
            WORK: begin
                x_d   = x_step;
                y_d   = y_step;
                m_d   = m_q >> 2;
                cnt_d = cnt_q - 1'b1;
                // Root settles in the low OUT_W bits; the residue is bounded by 2y.
                if (cnt_q == '0) begin
                    valid_d   = 1'b1;
                    y_res_d   = y_step[OUT_W-1:0];
                    rem_res_d = x_step[OUT_W:0];
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            valid_o <= 1'b0;
            y_bo    <= '0;
            rem_bo  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            valid_o <= valid_d;
            y_bo    <= y_res_d;
            rem_bo  <= rem_res_d;
        end
    end

endmodule

// File: tb/tb_sqrt_seq_param.sv
// Scoreboard bench for sqrt_seq_param at WIDTH=16 and WIDTH=8.
module tb_sqrt_seq_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       start16, start8;
    logic [15:0] x16;
    logic [7:0]  x8;
    logic       busy16, valid16, busy8, valid8;
    logic [7:0] y16;
    logic [8:0] rem16;
    logic [3:0] y8;
    logic [4:0] rem8;

    typedef struct {
        int x;
        int y;
        int rem;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_y16 = 0, last_r16 = 0, last_y8 = 0, last_r8 = 0;

    always #5 clk = ~clk;

    sqrt_seq_param #(.WIDTH(16)) u_dut16 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start16),
        .x_bi    (x16),
        .busy_o  (busy16),
        .valid_o (valid16),
        .y_bo    (y16),
        .rem_bo  (rem16)
    );

    sqrt_seq_param #(.WIDTH(8)) u_dut8 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start8),
        .x_bi    (x8),
        .busy_o  (busy8),
        .valid_o (valid8),
        .y_bo    (y8),
        .rem_bo  (rem8)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            last_y16 = 0;
            last_r16 = 0;
        end else if (valid16) begin
            if (q16.size() == 0) begin
                chk("unexpected_valid16", 1, 0);
            end else begin
                e16 = q16.pop_front();
                chk("y16", y16, e16.y);
                chk("rem16", rem16, e16.rem);
            end
            last_y16 = int'(y16);
            last_r16 = int'(rem16);
        end else begin
            chk("hold_y16", y16, last_y16);
            chk("hold_rem16", rem16, last_r16);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            last_y8 = 0;
            last_r8 = 0;
        end else if (valid8) begin
            if (q8.size() == 0) begin
                chk("unexpected_valid8", 1, 0);
            end else begin
                e8 = q8.pop_front();
                chk("y8", y8, e8.y);
                chk("rem8", rem8, e8.rem);
                chk("ident8", int'(y8) * int'(y8) + int'(rem8), e8.x);
                chk("rem_le_2y8", (int'(rem8) <= 2 * int'(y8)) ? 1 : 0, 1);
            end
            last_y8 = int'(y8);
            last_r8 = int'(rem8);
        end else begin
            chk("hold_y8", y8, last_y8);
            chk("hold_rem8", rem8, last_r8);
        end
    end

    // Returns #1 after the accepting edge with start already dropped.
    task automatic go16(input int x, input int ey, input int er);
        int g = 0;
        @(posedge clk); #1;
        while (busy16 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy16) chk("idle_timeout16", 1, 0);
        start16 = 1'b1;
        x16     = 16'(x);
        q16.push_back('{x, ey, er});
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic go8(input int x, input int ey, input int er);
        int g = 0;
        @(posedge clk); #1;
        while (busy8 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy8) chk("idle_timeout8", 1, 0);
        start8 = 1'b1;
        x8     = 8'(x);
        q8.push_back('{x, ey, er});
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait_done16();
        int g = 0;
        while ((q16.size() != 0 || busy16) && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        chk("drain16", q16.size(), 0);
    endtask

    task automatic wait_done8();
        int g = 0;
        while ((q8.size() != 0 || busy8) && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        chk("drain8", q8.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nbusy;
        int vals[3];
        rst = 1'b1; start16 = 1'b0; start8 = 1'b0; x16 = '0; x8 = '0;
        #1;
        chk("rst_busy16", busy16, 0);
        chk("rst_valid16", valid16, 0);
        chk("rst_y16", y16, 0);
        chk("rst_rem16", rem16, 0);
        chk("rst_y8", y8, 0);
        chk("rst_rem8", rem8, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Latency and busy length for x=144
        @(posedge clk); #1;
        start16 = 1'b1;
        x16     = 16'd144;
        q16.push_back('{144, 12, 0});
        @(posedge clk); #1;
        start16 = 1'b0;
        k = 0; nbusy = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (busy16) nbusy++;
            if (valid16) break;
        end
        chk("latency16", k - 1, 8);
        chk("busy_cycles16", nbusy, 8);
        wait_done16();

        go16(65535, 255, 510);
        go16(0, 0, 0);
        go16(143, 11, 22);
        wait_done16();

        // Re-pulse with a different operand while busy must be ignored
        go16(100, 10, 0);
        repeat (2) @(posedge clk);
        #1;
        start16 = 1'b1;
        x16     = 16'd9;
        @(posedge clk); #1;
        start16 = 1'b0;
        x16     = '0;
        wait_done16();
        repeat (12) @(posedge clk);
        chk("ignore_single16", q16.size(), 0);

        // Asynchronous abort mid-operation
        go16(200, 14, 4);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_busy16", busy16, 0);
        chk("abort_valid16", valid16, 0);
        chk("abort_y16", y16, 0);
        chk("abort_rem16", rem16, 0);
        q16.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        go16(50, 7, 1);
        wait_done16();

        // Back-to-back with start held high
        vals[0] = 1000; vals[1] = 30000; vals[2] = 5;
        @(posedge clk); #1;
        start16 = 1'b1;
        x16     = 16'(vals[0]);
        q16.push_back('{vals[0], isqrt(vals[0]), vals[0] - isqrt(vals[0]) ** 2});
        for (int i = 0; i < 3; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!valid16 && k < 30);
            if (i > 0) chk("interval16", k, 9);
            if (i < 2) begin
                x16 = 16'(vals[i + 1]);
                q16.push_back('{vals[i + 1], isqrt(vals[i + 1]),
                                vals[i + 1] - isqrt(vals[i + 1]) ** 2});
            end else begin
                start16 = 1'b0;
            end
        end
        wait_done16();

        // Exhaustive 8-bit sweep
        for (int x = 0; x < 256; x++) begin
            if (x == 255) go8(255, 15, 30);
            else          go8(x, isqrt(x), x - isqrt(x) * isqrt(x));
        end
        wait_done8();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
